// File: rtl/systolic_pe_mac.sv
// systolic_pe_mac: one processing element of the systolic matrix-multiply array.
// Forwards the skewed A (west->east) and B (north->south) operand streams with
// a one-cycle register stage, and multiply-accumulates K_DEPTH matched operand
// pairs into one C element.
// Optional feature: define SYSTOLIC_PE_MAC_MISMATCH_CHECK_EN to enable the sticky
// operand-alignment error flag (mismatch_err); otherwise it is tied to 0.
module systolic_pe_mac #(
  parameter int K_DEPTH = 4,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic        a_valid_in,
  input  logic [31:0] b_in,
  input  logic        b_valid_in,
  input  logic        acc_clear,
  output logic [31:0] a_out,
  output logic        a_valid_out,
  output logic [31:0] b_out,
  output logic        b_valid_out,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        mismatch_err
);

  // Counter value at which the next fire completes the C element.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_DEPTH - 1);

  logic [31:0]      a_out_q, a_out_d;
  logic             a_valid_out_q, a_valid_out_d;
  logic [31:0]      b_out_q, b_out_d;
  logic             b_valid_out_q, b_valid_out_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic             fire;
  logic [31:0]      product;

  // Both operands present this cycle; product keeps only the low 32 bits.
  assign fire    = a_valid_in & b_valid_in;
  assign product = a_in * b_in;

  // Next-state: pass-through plus the accumulate/complete/abort decision.
  always_comb begin
    a_out_d        = a_in;
    a_valid_out_d  = a_valid_in;
    b_out_d        = b_in;
    b_valid_out_d  = b_valid_in;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (acc_clear) begin
      // Abort wins over a same-cycle fire, even a completing one.
      acc_d = '0;
      cnt_d = '0;
    end else if (fire) begin
      if (cnt_q == LAST_CNT) begin
        result_d       = acc_q + product;
        result_valid_d = 1'b1;
        acc_d          = '0;
        cnt_d          = '0;
      end else begin
        acc_d = acc_q + product;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out_q        <= '0;
      a_valid_out_q  <= 1'b0;
      b_out_q        <= '0;
      b_valid_out_q  <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      a_out_q        <= a_out_d;
      a_valid_out_q  <= a_valid_out_d;
      b_out_q        <= b_out_d;
      b_valid_out_q  <= b_valid_out_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef SYSTOLIC_PE_MAC_MISMATCH_CHECK_EN
  logic mismatch_q, mismatch_d;

  // Sticky: any cycle where only one stream is valid latches the error until reset.
  always_comb begin
    mismatch_d = mismatch_q | (a_valid_in ^ b_valid_in);
  end

  // Error flag register; only reset clears it, acc_clear does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mismatch_q <= 1'b0;
    else      mismatch_q <= mismatch_d;
  end

  assign mismatch_err = mismatch_q;
`else
  assign mismatch_err = 1'b0;
`endif

  assign a_out        = a_out_q;
  assign a_valid_out  = a_valid_out_q;
  assign b_out        = b_out_q;
  assign b_valid_out  = b_valid_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: directed scenarios plus random traffic, checked
// every cycle against a queue-based model (products collected per C element,
// summed when K_DEPTH are present). A second instance runs with K_DEPTH=1.
module tb_systolic_pe_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic        a_valid_in, b_valid_in, acc_clear;

  logic [31:0] a_out, b_out, result;
  logic        a_valid_out, b_valid_out, result_valid, mismatch_err;
  logic [31:0] a_out1, b_out1, result1;
  logic        a_valid_out1, b_valid_out1, result_valid1, mismatch_err1;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [31:0] prods[$];
  logic [31:0] exp_a, exp_b, exp_res, exp_res1;
  logic        exp_av, exp_bv, exp_rv, exp_rv1, exp_mm;
  int          pulses;

  always #5 clk = ~clk;

  systolic_pe_mac #(.K_DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clear(acc_clear),
    .a_out(a_out), .a_valid_out(a_valid_out),
    .b_out(b_out), .b_valid_out(b_valid_out),
    .result(result), .result_valid(result_valid),
    .mismatch_err(mismatch_err)
  );

  systolic_pe_mac #(.K_DEPTH(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .acc_clear(acc_clear),
    .a_out(a_out1), .a_valid_out(a_valid_out1),
    .b_out(b_out1), .b_valid_out(b_valid_out1),
    .result(result1), .result_valid(result_valid1),
    .mismatch_err(mismatch_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prods.delete();
    exp_a = '0; exp_b = '0; exp_av = 1'b0; exp_bv = 1'b0;
    exp_res = '0; exp_rv = 1'b0; exp_res1 = '0; exp_rv1 = 1'b0;
    exp_mm = 1'b0;
  endtask

  // Reference behaviour for one clock edge with the given inputs applied.
  task automatic model_edge(input logic [31:0] a, input logic av, input logic [31:0] b,
                            input logic bv, input logic clr);
    logic [31:0] p, s;
    if (!rst) begin
      model_reset();
      return;
    end
    exp_a = a; exp_av = av; exp_b = b; exp_bv = bv;
    exp_rv = 1'b0; exp_rv1 = 1'b0;
    if (clr) begin
      prods.delete();
    end else if (av && bv) begin
      p = a * b;
      prods.push_back(p);
      if (prods.size() == 4) begin
        s = '0;
        foreach (prods[i]) s = s + prods[i];
        exp_res = s;
        exp_rv  = 1'b1;
        prods.delete();
      end
      exp_res1 = p;
      exp_rv1  = 1'b1;
    end
`ifdef SYSTOLIC_PE_MAC_MISMATCH_CHECK_EN
    if (av != bv) exp_mm = 1'b1;
`endif
  endtask

  task automatic check_all();
    chk("a_out", a_out, exp_a);
    chk("a_valid_out", {31'd0, a_valid_out}, {31'd0, exp_av});
    chk("b_out", b_out, exp_b);
    chk("b_valid_out", {31'd0, b_valid_out}, {31'd0, exp_bv});
    chk("result", result, exp_res);
    chk("result_valid", {31'd0, result_valid}, {31'd0, exp_rv});
    chk("mismatch_err", {31'd0, mismatch_err}, {31'd0, exp_mm});
    chk("k1_result", result1, exp_res1);
    chk("k1_result_valid", {31'd0, result_valid1}, {31'd0, exp_rv1});
    if (result_valid) pulses++;
  endtask

  task automatic step(input logic [31:0] a, input logic av, input logic [31:0] b,
                      input logic bv, input logic clr);
    a_in = a; a_valid_in = av; b_in = b; b_valid_in = bv; acc_clear = clr;
    @(posedge clk);
    #1;
    model_edge(a, av, b, bv, clr);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    step($urandom, 1'b1, $urandom, 1'b1, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    a_in = '0; b_in = '0; a_valid_in = 1'b0; b_valid_in = 1'b0; acc_clear = 1'b0;
    model_reset();
    pulses = 0;

    // Reset held 3 cycles with random inputs
    for (int i = 0; i < 3; i++)
      step($urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    rst = 1'b1;
    step(32'd5, 1'b1, 32'd0, 1'b0, 1'b0);
    chk("post_reset_a_out", a_out, 32'd5);
    chk("post_reset_a_valid", {31'd0, a_valid_out}, 32'd1);
    do_reset();

    // Basic dot product
    step(1, 1, 2, 1, 0); step(3, 1, 4, 1, 0); step(5, 1, 6, 1, 0);
    chk("dot_no_early_pulse", {31'd0, result_valid}, 32'd0);
    step(7, 1, 8, 1, 0);
    chk("dot_result", result, 32'd100);
    chk("dot_valid", {31'd0, result_valid}, 32'd1);
    idle(1);
    chk("dot_valid_one_cycle", {31'd0, result_valid}, 32'd0);
    chk("dot_result_hold", result, 32'd100);

    // Gaps, then back-to-back accumulation
    pulses = 0;
    step(1, 1, 2, 1, 0); idle(2); step(3, 1, 4, 1, 0); idle(2);
    step(5, 1, 6, 1, 0); idle(2); step(7, 1, 8, 1, 0);
    chk("gap_result", result, 32'd100);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
    chk("b2b_result", result, 32'd4);
    idle(1);
    chk("b2b_pulses", pulses, 32'd2);

    // Wraparound and product truncation
    step(32'hFFFF_FFFF, 1, 1, 1, 0); step(1, 1, 1, 1, 0);
    step(32'h10000, 1, 32'h10000, 1, 0); step(0, 1, 0, 1, 0);
    chk("wrap_result", result, 32'd0);
    chk("wrap_valid", {31'd0, result_valid}, 32'd1);

    // acc_clear with 3rd fire, then fresh accumulation
    step(9, 1, 9, 1, 0); step(9, 1, 9, 1, 0); step(9, 1, 9, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
    chk("clear_restart_result", result, 32'd4);

    // acc_clear with a completing fire discards it
    step(2, 1, 2, 1, 0); step(2, 1, 2, 1, 0); step(2, 1, 2, 1, 0); step(2, 1, 2, 1, 1);
    chk("clear_completing_valid", {31'd0, result_valid}, 32'd0);
    chk("clear_completing_result", result, 32'd4);

    // Reset mid-accumulation drops the partial sum
    step(50, 1, 50, 1, 0); step(50, 1, 50, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
    chk("reset_mid_result", result, 32'd4);

    // Mismatch flag: sticky through acc_clear, cleared by reset
    step(3, 1, 3, 0, 0);
`ifdef SYSTOLIC_PE_MAC_MISMATCH_CHECK_EN
    chk("mm_set", {31'd0, mismatch_err}, 32'd1);
    step(0, 0, 0, 0, 1);
    chk("mm_sticky", {31'd0, mismatch_err}, 32'd1);
`else
    chk("mm_off", {31'd0, mismatch_err}, 32'd0);
    step(0, 0, 0, 0, 1);
`endif
    do_reset();
    chk("mm_cleared", {31'd0, mismatch_err}, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, av, bv, clr;
      logic [31:0] a, b;
      v  = ($urandom_range(0, 3) != 0);
      av = v; bv = v;
      if ($urandom_range(0, 99) == 0) bv = ~bv;
      clr = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
      b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
      step(a, av, b, bv, clr);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
